// File: rtl/xor_parity_sched.sv
// Two-requester parity scheduler sharing a single 1-bit XOR cell through a
// round-robin arbiter. Define XOR_PAR_ODD_EN for odd parity (reset value 1).
module xor_parity_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             ack0,
  output logic             ack1,
  output logic             parity
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);

`ifdef XOR_PAR_ODD_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             last_one;  // 1: requester 1 was served most recently
  logic             pick_one;

  function automatic logic finish_parity(input logic a);
    return a ^ PAR_INV;
  endfunction

  // Requester 1 wins when alone, or when both ask and requester 0 went last.
  always_comb begin
    pick_one = req1 && (!req0 || !last_one);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 2'b00;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      parity   <= PAR_INV;
      sreg     <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
      last_one <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant <= pick_one ? 2'b10 : 2'b01;
            sreg  <= pick_one ? data1 : data0;
            acc   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The counter saturates at WIDTH; that terminal cycle hands off to DONE.
          if (cnt == CNT_END) begin
            state <= DONE;
          end else begin
            acc  <= acc ^ sreg[0];
            sreg <= sreg >> 1;
            cnt  <= cnt + 1'b1;
          end
        end
        DONE: begin
          parity   <= finish_parity(acc);
          ack0     <= grant[0];
          ack1     <= grant[1];
          last_one <= grant[1];
          grant    <= 2'b00;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_sched.sv
// Directed bench for xor_parity_sched: an 8-bit instance plus a 2-bit instance.
module tb_xor_parity_sched;

`ifdef XOR_PAR_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic [1:0] grant;
  logic       busy, ack0, ack1, parity;

  logic       w_req0 = 1'b0, w_req1 = 1'b0;
  logic [1:0] w_data0 = '0, w_data1 = '0;
  logic [1:0] w_grant;
  logic       w_busy, w_ack0, w_ack1, w_parity;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xor_parity_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .grant(grant), .busy(busy), .ack0(ack0), .ack1(ack1), .parity(parity)
  );

  xor_parity_sched #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .req0(w_req0), .data0(w_data0), .req1(w_req1), .data1(w_data1),
    .grant(w_grant), .busy(w_busy), .ack0(w_ack0), .ack1(w_ack1), .parity(w_parity)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1;
    data0 = 8'hB5;
    step();
    step();
    checks++;
    if ({grant, busy, ack0, ack1, parity} !== {2'b00, 1'b0, 1'b0, 1'b0, ODD}) begin
      failures++;
      $display("FAIL reset_outputs: got grant=%b busy=%b ack0=%b ack1=%b parity=%b, need 00 0 0 0 %b",
               grant, busy, ack0, ack1, parity, ODD);
    end
    req0 = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n;
    int k;
    logic held;
    req0 = 1'b1;
    data0 = 8'hB5;
    n = 0;
    while (grant == 2'b00 && n < 40) begin step(); n++; end
    checks++;
    if (grant !== 2'b01 || n != 1) begin
      failures++;
      $display("FAIL single_grant: got grant=%b after %0d cycles, need 01 after 1", grant, n);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: got %b need 1", busy);
    end
    k = 0;
    held = 1'b1;
    while (!ack0 && k < 40) begin
      step();
      k++;
      if (!ack0 && grant !== 2'b01) held = 1'b0;
    end
    req0 = 1'b0;
    checks++;
    if (k != 10) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles need 10", k);
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL single_grant_hold: grant changed before ack, need 01 throughout");
    end
    checks++;
    if (parity !== (1'b1 ^ ODD) || ack1 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got parity=%b ack1=%b busy=%b need %b 0 0", parity, ack1, busy, 1'b1 ^ ODD);
    end
    step();
    checks++;
    if (ack0 !== 1'b0 || grant !== 2'b00 || parity !== (1'b1 ^ ODD)) begin
      failures++;
      $display("FAIL single_pulse: got ack0=%b grant=%b parity=%b need 0 00 %b", ack0, grant, parity, 1'b1 ^ ODD);
    end
  endtask

  task automatic test_same_cycle();
    int n;
    apply_reset();
    req0 = 1'b1; data0 = 8'h03;
    req1 = 1'b1; data1 = 8'h07;
    n = 0;
    while (grant == 2'b00 && n < 40) begin step(); n++; end
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL same_first_grant: got %b need 01", grant);
    end
    n = 0;
    while (!ack0 && !ack1 && n < 40) begin step(); n++; end
    req0 = 1'b0;
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || parity !== (1'b0 ^ ODD)) begin
      failures++;
      $display("FAIL same_first_result: got ack0=%b ack1=%b parity=%b need 1 0 %b", ack0, ack1, parity, ODD);
    end
    n = 0;
    while (grant == 2'b00 && n < 40) begin step(); n++; end
    checks++;
    if (grant !== 2'b10 || n != 1) begin
      failures++;
      $display("FAIL same_second_grant: got %b after %0d cycles need 10 after 1", grant, n);
    end
    n = 0;
    while (!ack0 && !ack1 && n < 40) begin step(); n++; end
    req1 = 1'b0;
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || parity !== (1'b1 ^ ODD)) begin
      failures++;
      $display("FAIL same_second_result: got ack1=%b ack0=%b parity=%b need 1 0 %b", ack1, ack0, parity, 1'b1 ^ ODD);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [1:0] exp_g;
    apply_reset();
    req0 = 1'b1; data0 = 8'h01;
    req1 = 1'b1; data1 = 8'h03;
    for (int op = 0; op < 4; op++) begin
      exp_g = op[0] ? 2'b10 : 2'b01;
      n = 0;
      while (grant == 2'b00 && n < 40) begin step(); n++; end
      checks++;
      if (grant !== exp_g) begin
        failures++;
        $display("FAIL b2b_grant%0d: got %b need %b", op, grant, exp_g);
      end
      n = 0;
      while (!ack0 && !ack1 && n < 40) begin step(); n++; end
      checks++;
      if ({ack1, ack0} !== exp_g || parity !== (~op[0] ^ ODD)) begin
        failures++;
        $display("FAIL b2b_ack%0d: got acks=%b parity=%b need %b %b", op, {ack1, ack0}, parity, exp_g, ~op[0] ^ ODD);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
  endtask

  task automatic test_data_change();
    int n;
    req1 = 1'b1;
    data1 = 8'hFF;
    n = 0;
    while (grant == 2'b00 && n < 40) begin step(); n++; end
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL chg_grant: got %b need 10", grant);
    end
    step();
    data1 = 8'h01;
    req1 = 1'b0;
    n = 0;
    while (!ack1 && n < 40) begin step(); n++; end
    checks++;
    if (ack1 !== 1'b1 || parity !== (1'b0 ^ ODD)) begin
      failures++;
      $display("FAIL chg_result: got ack1=%b parity=%b need 1 %b", ack1, parity, ODD);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_ack;
    req0 = 1'b1;
    data0 = 8'hB5;
    n = 0;
    while (grant == 2'b00 && n < 40) begin step(); n++; end
    step(); step(); step();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({grant, busy, ack0, ack1, parity} !== {2'b00, 1'b0, 1'b0, 1'b0, ODD}) begin
      failures++;
      $display("FAIL midrst_outputs: got grant=%b busy=%b ack0=%b ack1=%b parity=%b need 00 0 0 0 %b",
               grant, busy, ack0, ack1, parity, ODD);
    end
    saw_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack0 || ack1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin
      failures++;
      $display("FAIL midrst_no_ack: got an ack during reset, need none");
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL midrst_regrant: got %b need 01", grant);
    end
    n = 0;
    while (!ack0 && n < 40) begin step(); n++; end
    req0 = 1'b0;
    checks++;
    if (n != 10 || parity !== (1'b1 ^ ODD)) begin
      failures++;
      $display("FAIL midrst_complete: got latency=%0d parity=%b need 10 %b", n, parity, 1'b1 ^ ODD);
    end
    step();
  endtask

  task automatic test_width2();
    int n;
    w_req0 = 1'b1;
    w_data0 = 2'b10;
    n = 0;
    while (w_grant == 2'b00 && n < 40) begin step(); n++; end
    checks++;
    if (w_grant !== 2'b01) begin
      failures++;
      $display("FAIL w2_grant: got %b need 01", w_grant);
    end
    n = 0;
    while (!w_ack0 && n < 40) begin step(); n++; end
    w_req0 = 1'b0;
    checks++;
    if (n != 4 || w_parity !== (1'b1 ^ ODD)) begin
      failures++;
      $display("FAIL w2_result: got latency=%0d parity=%b need 4 %b", n, w_parity, 1'b1 ^ ODD);
    end
    step();
  endtask

  always @(negedge clk) begin
    if (rst_n && ack0 && ack1) begin
      checks++;
      failures++;
      $display("FAIL ack_overlap: got ack0=1 ack1=1 need at most one");
    end
  end

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_back_to_back();
    test_data_change();
    test_reset_mid();
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
